// File: rtl/simon_pkg.sv
// Shared Simon definitions: bus width, encryptor FSM states and width-generic
// rotate / round-function helpers (operands carried in 64 bits, masked to w).
package simon_pkg;

    localparam int SIMON_BUS_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } simon_enc_state_t;

    function automatic logic [63:0] simon_mask(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] simon_rotl(input logic [63:0] x,
                                               input int unsigned r,
                                               input int unsigned w);
        logic [63:0] xm;
        xm = x & simon_mask(w);
        return ((xm << r) | (xm >> (w - r))) & simon_mask(w);
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] x,
                                            input int unsigned w);
        return (simon_rotl(x, 1, w) & simon_rotl(x, 8, w)) ^ simon_rotl(x, 2, w);
    endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational Simon Feistel round: x' = y ^ f(x) ^ k, y' = x.
module simon_round
    import simon_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] k,
    output logic [WORD_W-1:0] x_next,
    output logic [WORD_W-1:0] y_next
);

    logic [WORD_W-1:0] f;

    assign f      = WORD_W'(simon_f(64'(x), WORD_W));
    assign x_next = y ^ f ^ k;
    assign y_next = x;

endmodule

// File: rtl/simon_enc_rounds.sv
// Iterative Simon encryptor: one plaintext block in flight, one round per
// accepted subkey beat, ciphertext held on a valid/ready port until taken.
module simon_enc_rounds
    import simon_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 44
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIMON_BUS_W-1:0] pt_in,
    input  logic                   pt_in_vld,
    output logic                   pt_in_rdy,
    input  logic [SIMON_BUS_W-1:0] subkey_in,
    input  logic                   subkey_in_vld,
    output logic                   subkey_in_rdy,
    output logic [SIMON_BUS_W-1:0] ct_out,
    output logic                   ct_out_vld,
    input  logic                   ct_out_rdy,
    output logic                   busy
);

    localparam int CNT_W = $clog2(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS - 1);

    simon_enc_state_t  state_reg;
    logic [WORD_W-1:0] x_reg;
    logic [WORD_W-1:0] y_reg;
    logic [CNT_W-1:0]  rnd_cnt_reg;
    logic [WORD_W-1:0] x_next;
    logic [WORD_W-1:0] y_next;
    logic              unused_bits;

    simon_round #(
        .WORD_W (WORD_W)
    ) u_round (
        .x      (x_reg),
        .y      (y_reg),
        .k      (subkey_in[WORD_W-1:0]),
        .x_next (x_next),
        .y_next (y_next)
    );

    // Handshake outputs are pure state decodes, so no valid/ready input can
    // reach them combinationally.
    assign pt_in_rdy     = (state_reg == IDLE);
    assign subkey_in_rdy = (state_reg == RUN);
    assign ct_out_vld    = (state_reg == DONE);
    assign busy          = (state_reg != IDLE);
    assign ct_out        = (state_reg == DONE)
                         ? {{(SIMON_BUS_W - 2*WORD_W){1'b0}}, x_reg, y_reg}
                         : '0;

    assign unused_bits = ^{pt_in[SIMON_BUS_W-1:2*WORD_W], subkey_in[SIMON_BUS_W-1:WORD_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            rnd_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pt_in_vld) begin
                        x_reg       <= pt_in[2*WORD_W-1:WORD_W];
                        y_reg       <= pt_in[WORD_W-1:0];
                        rnd_cnt_reg <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (subkey_in_vld) begin
                        x_reg <= x_next;
                        y_reg <= y_next;
                        // The counter parks on the last index instead of wrapping.
                        if (rnd_cnt_reg == LAST_RND) begin
                            state_reg <= DONE;
                        end else begin
                            rnd_cnt_reg <= rnd_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (ct_out_rdy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
